// File: rtl/sel_led_pkg.sv
// rtl/sel_led_pkg.sv - shared types and helpers for the sel LED blink-code indicator
//
// Purpose: FSM state encoding, select width and counter width helper shared by
//          sel_led_indicator and sel_led_timer.
// Ports:   none (package).
// Config:  SEL_LED_RESTART_ON_CHANGE_EN is consumed by sel_led_indicator, not here.

package sel_led_pkg;

  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  // The counter is only ever loaded with (phase length - 1), so $clog2 of the
  // longest phase is enough bits; clamp to 1 so a design with all phases of one
  // cycle still gets a legal vector.
  function automatic int cnt_width(input int on_cycles, input int off_cycles,
                                   input int gap_cycles);
    int m;
    m = on_cycles;
    if (off_cycles > m) m = off_cycles;
    if (gap_cycles > m) m = gap_cycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sel_led_timer.sv
// rtl/sel_led_timer.sv - loadable saturating down-counter with registered done flag
//
// Purpose: times the ON, OFF and GAP phases. A load strobe sets the count; with
//          no load it counts down by one per cycle and holds at zero.
// Ports:
//   clk         input   system clock
//   reset       input   synchronous active-low reset (count cleared, done set)
//   load        input   load strobe, takes priority over counting
//   load_value  input   value loaded on load (phase length - 1)
//   done        output  registered, high while the count is zero

module sel_led_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] cnt;

  // done is kept in step with cnt so it equals (cnt == 0) from a flop
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= '0;
      done <= 1'b1;
    end else if (load) begin
      cnt  <= load_value;
      done <= (load_value == '0);
    end else if (cnt != '0) begin
      cnt  <= cnt - W'(1);
      done <= (cnt == W'(1));
    end
  end

endmodule

// File: rtl/sel_led_indicator.sv
// rtl/sel_led_indicator.sv - shows the 2-bit sel state as a repeating LED blink code
//
// Purpose: each frame is sel+1 LED pulses (ON high, OFF low between pulses)
//          followed by a GAP low period, repeated with no dead cycles. sel is
//          latched at frame start.
// Config:  `define SEL_LED_RESTART_ON_CHANGE_EN to abort a frame in ON/OFF when
//          sel differs from the latched value (jumps to a full GAP).
// Ports:
//   clk          input   system clock
//   reset        input   synchronous active-low reset
//   sel          input   state to display (0..3, 3 shows as four pulses)
//   led          output  registered LED drive, high = lit
//   frame_start  output  registered pulse in the first ON cycle of each frame
//   busy_sel     output  registered sel value latched for the current frame

module sel_led_indicator
  import sel_led_pkg::*;
#(
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 25000000,
  parameter int GAP_CYCLES = 100000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel,
  output logic             led,
  output logic             frame_start,
  output logic [SEL_W-1:0] busy_sel
);

  localparam int CNT_W = cnt_width(ON_CYCLES, OFF_CYCLES, GAP_CYCLES);

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] pulses_left_q, pulses_left_d;
  logic             led_d;
  logic             frame_start_d;
  logic [SEL_W-1:0] busy_sel_d;
  logic             start_frame;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_value;
  logic             tmr_done;

  sel_led_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .done       (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      pulses_left_q <= '0;
      led           <= 1'b0;
      frame_start   <= 1'b0;
      busy_sel      <= '0;
    end else begin
      state_q       <= state_d;
      pulses_left_q <= pulses_left_d;
      led           <= led_d;
      frame_start   <= frame_start_d;
      busy_sel      <= busy_sel_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pulses_left_d  = pulses_left_q;
    led_d          = led;
    frame_start_d  = 1'b0;
    busy_sel_d     = busy_sel;
    start_frame    = 1'b0;
    tmr_load       = 1'b0;
    tmr_load_value = ON_LOAD;

    case (state_q)
      IDLE: start_frame = 1'b1;
      GAP:  start_frame = tmr_done;
      ON: begin
        if (tmr_done) begin
          led_d    = 1'b0;
          tmr_load = 1'b1;
          // pulses_left counts the pulses still owed after this one
          if (pulses_left_q != '0) begin
            state_d        = OFF;
            tmr_load_value = OFF_LOAD;
          end else begin
            state_d        = GAP;
            tmr_load_value = GAP_LOAD;
          end
        end
      end
      OFF: begin
        if (tmr_done) begin
          pulses_left_d  = pulses_left_q - SEL_W'(1);
          state_d        = ON;
          led_d          = 1'b1;
          tmr_load       = 1'b1;
          tmr_load_value = ON_LOAD;
        end
      end
      default: start_frame = 1'b1;
    endcase

    // Frame start is shared by the IDLE exit and the GAP wrap so both behave
    // identically; there is never an idle cycle between frames.
    if (start_frame) begin
      busy_sel_d     = sel;
      pulses_left_d  = sel;
      led_d          = 1'b1;
      frame_start_d  = 1'b1;
      state_d        = ON;
      tmr_load       = 1'b1;
      tmr_load_value = ON_LOAD;
    end

`ifdef SEL_LED_RESTART_ON_CHANGE_EN
    // GAP is excluded: it resamples sel at its end anyway.
    if ((state_q == ON || state_q == OFF) && (sel != busy_sel)) begin
      state_d        = GAP;
      led_d          = 1'b0;
      pulses_left_d  = pulses_left_q;
      tmr_load       = 1'b1;
      tmr_load_value = GAP_LOAD;
    end
`endif
  end

endmodule

// File: tb/tb_sel_led_indicator.sv
// tb/tb_sel_led_indicator.sv - self-checking bench for sel_led_indicator (ON=3, OFF=2, GAP=5)

module tb_sel_led_indicator;

  localparam int ON_C  = 3;
  localparam int OFF_C = 2;
  localparam int GAP_C = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       led;
  logic       frame_start;
  logic [1:0] busy_sel;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // reference model: the rest of the current frame as a list of LED levels
  logic       exp_q[$];
  logic       exp_led = 1'b0;
  logic       exp_fs = 1'b0;
  logic [1:0] exp_busy = 2'd0;

  sel_led_indicator #(
    .ON_CYCLES  (ON_C),
    .OFF_CYCLES (OFF_C),
    .GAP_CYCLES (GAP_C)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sel         (sel),
    .led         (led),
    .frame_start (frame_start),
    .busy_sel    (busy_sel)
  );

  always #5 clk = ~clk;

  task automatic build_frame(input logic [1:0] s);
    exp_q.delete();
    for (int p = 0; p <= int'(s); p++) begin
      for (int i = 0; i < ON_C; i++) exp_q.push_back(1'b1);
      if (p < int'(s)) for (int i = 0; i < OFF_C; i++) exp_q.push_back(1'b0);
    end
    for (int i = 0; i < GAP_C; i++) exp_q.push_back(1'b0);
  endtask

  // Predicts the outputs after one rising edge with the given inputs.
  task automatic model_step(input logic r, input logic [1:0] s);
    if (!r) begin
      exp_q.delete();
      exp_led  = 1'b0;
      exp_fs   = 1'b0;
      exp_busy = 2'd0;
    end else begin
      if (exp_q.size() == 0) begin
        build_frame(s);
        exp_busy = s;
        exp_fs   = 1'b1;
      end else begin
        exp_fs = 1'b0;
`ifdef SEL_LED_RESTART_ON_CHANGE_EN
        // at least GAP_C entries left means the level just shown was a pulse/OFF cycle
        if (exp_q.size() >= GAP_C && s != exp_busy) begin
          exp_q.delete();
          for (int i = 0; i < GAP_C; i++) exp_q.push_back(1'b0);
        end
`endif
      end
      exp_led = exp_q.pop_front();
    end
  endtask

  task automatic tick(input logic r, input logic [1:0] s);
    @(negedge clk);
    reset = r;
    sel   = s;
    @(posedge clk);
    model_step(r, s);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 2'd0);
      vectors += 3;
      if (led !== 1'b0) begin miscompares++; $display("FAIL reset_led cyc=%0d got=%b want=0", cyc, led); end
      if (frame_start !== 1'b0) begin miscompares++; $display("FAIL reset_fs cyc=%0d got=%b want=0", cyc, frame_start); end
      if (busy_sel !== 2'd0) begin miscompares++; $display("FAIL reset_busy cyc=%0d got=%0d want=0", cyc, busy_sel); end
    end
  endtask

  task automatic test_hold_sel(input logic [1:0] s, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      tick(1'b1, s);
      vectors += 3;
      if (led !== exp_led) begin miscompares++; $display("FAIL hold%0d_led cyc=%0d got=%b want=%b", s, cyc, led, exp_led); end
      if (frame_start !== exp_fs) begin miscompares++; $display("FAIL hold%0d_fs cyc=%0d got=%b want=%b", s, cyc, frame_start, exp_fs); end
      if (busy_sel !== exp_busy) begin miscompares++; $display("FAIL hold%0d_busy cyc=%0d got=%0d want=%0d", s, cyc, busy_sel, exp_busy); end
    end
  endtask

  task automatic test_sel3_period();
    int last_fs;
    int periods;
    last_fs = -1;
    periods = 0;
    for (int i = 0; i < 2; i++) tick(1'b0, 2'd3);
    for (int i = 0; i < 3 * 23 + 2; i++) begin
      tick(1'b1, 2'd3);
      vectors += 2;
      if (led !== exp_led) begin miscompares++; $display("FAIL sel3_led cyc=%0d got=%b want=%b", cyc, led, exp_led); end
      if (frame_start !== exp_fs) begin miscompares++; $display("FAIL sel3_fs cyc=%0d got=%b want=%b", cyc, frame_start, exp_fs); end
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          periods++;
          vectors++;
          if (cyc - last_fs !== 4 * ON_C + 3 * OFF_C + GAP_C) begin
            miscompares++;
            $display("FAIL sel3_period cyc=%0d got=%0d want=%0d", cyc, cyc - last_fs, 4 * ON_C + 3 * OFF_C + GAP_C);
          end
        end
        last_fs = cyc;
      end
    end
    vectors++;
    if (periods !== 3) begin miscompares++; $display("FAIL sel3_frames got=%0d want=3", periods); end
  endtask

  task automatic test_sel_change();
    logic [1:0] s;
    for (int i = 0; i < 2; i++) tick(1'b0, 2'd1);
    for (int i = 0; i < 40; i++) begin
      s = (i == 0) ? 2'd1 : 2'd2;   // change lands on the second cycle of the first ON pulse
      tick(1'b1, s);
      vectors += 3;
      if (led !== exp_led) begin miscompares++; $display("FAIL chg_led cyc=%0d got=%b want=%b", cyc, led, exp_led); end
      if (frame_start !== exp_fs) begin miscompares++; $display("FAIL chg_fs cyc=%0d got=%b want=%b", cyc, frame_start, exp_fs); end
      if (busy_sel !== exp_busy) begin miscompares++; $display("FAIL chg_busy cyc=%0d got=%0d want=%0d", cyc, busy_sel, exp_busy); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic r;
    for (int i = 0; i < 2; i++) tick(1'b0, 2'd2);
    // 9 ticks end on the first cycle of the second OFF; the 10th is the reset edge
    for (int i = 0; i < 30; i++) begin
      r = (i == 9 || i == 10) ? 1'b0 : 1'b1;
      tick(r, 2'd2);
      vectors += 3;
      if (led !== exp_led) begin miscompares++; $display("FAIL rstmid_led cyc=%0d got=%b want=%b", cyc, led, exp_led); end
      if (frame_start !== exp_fs) begin miscompares++; $display("FAIL rstmid_fs cyc=%0d got=%b want=%b", cyc, frame_start, exp_fs); end
      if (busy_sel !== exp_busy) begin miscompares++; $display("FAIL rstmid_busy cyc=%0d got=%0d want=%0d", cyc, busy_sel, exp_busy); end
    end
  endtask

  task automatic test_random();
    logic       r;
    logic [1:0] s;
    s = 2'($urandom_range(0, 3));
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) s = 2'($urandom_range(0, 3));
      r = ($urandom_range(0, 120) == 0) ? 1'b0 : 1'b1;
      tick(r, s);
      vectors += 3;
      if (led !== exp_led) begin miscompares++; $display("FAIL rand_led cyc=%0d got=%b want=%b", cyc, led, exp_led); end
      if (frame_start !== exp_fs) begin miscompares++; $display("FAIL rand_fs cyc=%0d got=%b want=%b", cyc, frame_start, exp_fs); end
      if (busy_sel !== exp_busy) begin miscompares++; $display("FAIL rand_busy cyc=%0d got=%0d want=%0d", cyc, busy_sel, exp_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_hold_sel(2'd0, 24);
    for (int i = 0; i < 2; i++) tick(1'b0, 2'd2);
    test_hold_sel(2'd2, 40);
    test_sel3_period();
    test_sel_change();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sel_led_indicator.md
Name: sel_led_indicator

Overview:
- Output-side companion to the 3-state switch controller: converts the 2-bit `sel` state into a human-readable LED blink code.
- Each frame is `sel+1` LED pulses followed by a long gap, repeated forever.
- Sits between the switch controller's `sel` output and a board LED pin; it is the visual readback of the button-selected mode.

Parameters:
- ON_CYCLES, 25000000, cycles LED is high per pulse (>=1)
- OFF_CYCLES, 25000000, cycles LED is low between pulses within a frame (>=1)
- GAP_CYCLES, 100000000, cycles LED is low after the last pulse of a frame (>=1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- sel  input  2  state to display (0..3)
- led  output  1  registered LED drive, high = lit
- frame_start  output  1  registered one-cycle pulse, high in the first ON cycle of every frame
- busy_sel  output  2  registered copy of the `sel` value latched for the current frame

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous, active-low (`reset`==0 sampled on a `clk` edge resets).
- Reset values: state=IDLE, led=0, frame_start=0, busy_sel=0, counters=0.
- States: IDLE, ON, OFF, GAP.
- IDLE: entered only from reset. On the first edge with reset=1:
  - latch sel into busy_sel; pulses_left <= sel;
  - led <= 1, frame_start <= 1, cnt <= ON_CYCLES-1; go to ON.
  - led therefore rises exactly one cycle after reset release.
- ON: led=1. frame_start=1 only in the first ON cycle of a frame (0 for later pulses and all other states). Decrement cnt each cycle. At cnt==0:
  - if pulses_left!=0: go to OFF, cnt <= OFF_CYCLES-1, led <= 0;
  - else: go to GAP, cnt <= GAP_CYCLES-1, led <= 0.
- OFF: led=0. At cnt==0: pulses_left <= pulses_left-1, go to ON, cnt <= ON_CYCLES-1, led <= 1.
- GAP: led=0. At cnt==0: resample sel and start a new frame exactly as the IDLE exit. There is no IDLE cycle between frames.
- Frame length: (sel+1)*ON + sel*OFF + GAP cycles, with no dead cycles.
- sel=3 is displayed as 4 pulses (the block does not police the controller's 0..2 range).
- sel is sampled only at frame start. Changes mid-frame take effect at the next frame (unless the optional feature is compiled in).
- Counter width: $clog2 of max(ON_CYCLES, OFF_CYCLES, GAP_CYCLES). Plain down-counter, never wraps below 0. pulses_left is 2 bits.
- Reset mid-frame: led drops to 0 on the reset edge; the frame restarts from IDLE after release.

Optional Feature:
- Macro: SEL_LED_RESTART_ON_CHANGE_EN.
- Defined:
  - In ON or OFF, if sel != busy_sel, abort the frame on the next edge: led <= 0, go to GAP with cnt <= GAP_CYCLES-1.
  - The new value is then shown after one full gap.
  - No abort check in GAP, since GAP already resamples at its end.
- Undefined: no abort; sel is ignored mid-frame and the comparator is not built.

Decomposition:
- Shared package sel_led_pkg:
  - state enum typedef {IDLE, ON, OFF, GAP};
  - SEL_W=2 constant;
  - function computing counter width from the three parameters.
- One natural sub-module: sel_led_timer. It holds a loadable down-counter with a load value input, load strobe, and registered `done` (cnt==0) output. It is reused for the ON/OFF/GAP phases.
- FSM and outputs stay in the top module.

Test Plan (ON=3, OFF=2, GAP=5):
- Reset held low 4 cycles, sel=0, release → led=1 and frame_start=1 one cycle after release; led pattern 1,1,1,0,0,0,0,0 repeating (period 8); frame_start every 8 cycles.
- sel=2 held → per frame led 111 00 111 00 111 00000 (18 cycles); busy_sel=2; frame_start once per 18 cycles.
- sel=3 → 4 pulses, frame 3*4+2*3+5=23 cycles.
- sel changes 1→2 during the first ON pulse (feature off) → current frame keeps 2 pulses (13 cycles); next frame shows 3 pulses and busy_sel=2.
- Same stimulus with SEL_LED_RESTART_ON_CHANGE_EN → led=0 on the edge after the change; 5 gap cycles; then a 3-pulse frame with frame_start=1.
- reset low during the second OFF phase of sel=2 → led=0 and busy_sel=0 on the reset edge; after release a fresh frame starts with frame_start one cycle later.
